mtimer: RTL and testbench

MTIMER -- requirements
Module: mtimer

---
 rtl/mtimer_pkg.sv | 26 ++
 rtl/mtimer.sv | 96 +++++++++
 tb/tb_mtimer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mtimer_pkg.sv
// Shared defines for the machine timer: register window offsets, CSR numbers,
// response record and the byte-strobe merge helper.
package mtimer_pkg;

    localparam logic [63:0] MTIMECMP_OFF = 64'h4000;
    localparam logic [63:0] MTIME_OFF    = 64'hBFF8;

    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } mtimer_rsp_t;

    // Bytes whose strobe is set take the new data; the rest keep the old value.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int b = 0; b < 8; b++)
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mtimer.sv
// RISC-V machine timer: free-running mtime with prescaler, mtimecmp compare,
// and a single-outstanding request/response register port.
module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timer_int_o,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        int_q;
    logic        rsp_valid_q, rsp_valid_d;
    mtimer_rsp_t rsp_q, rsp_d;

    logic accept, aligned, hit_cmp, hit_time, tick;

    always_comb begin
        accept   = req_valid & ~rsp_valid_q;
        aligned  = (req_addr[2:0] == 3'b000);
        hit_cmp  = aligned && (req_addr == BASE_ADDR + MTIMECMP_OFF);
        hit_time = aligned && (req_addr == BASE_ADDR + MTIME_OFF);
        tick     = (presc_q == PRESC_MAX);
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;

        // A software write to mtime wins over the tick on the same edge.
        mtime_d = mtime_q;
        if (accept && req_we && hit_time)
            mtime_d = strb_merge(mtime_q, req_wdata, req_wstrb);
        else if (tick)
            mtime_d = mtime_q + 64'd1;

        cmp_d = cmp_q;
        if (accept && req_we && hit_cmp)
            cmp_d = strb_merge(cmp_q, req_wdata, req_wstrb);

        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_d.err   = ~(hit_cmp | hit_time);
            rsp_d.rdata = 64'd0;
            if (!req_we && hit_cmp)
                rsp_d.rdata = cmp_q;
            else if (!req_we && hit_time)
                rsp_d.rdata = mtime_q;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= 16'd0;
            mtime_q     <= 64'd0;
            cmp_q       <= '1;
            int_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            cmp_q       <= cmp_d;
            int_q       <= (mtime_q >= cmp_q);
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready   = ~rsp_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign timer_int_o = int_q;
    assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: a TICK_DIV=1 instance drives the bus scenarios,
// a TICK_DIV=4 instance checks prescaling; responses are scoreboarded.
module tb_mtimer;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_CMP = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err, timer_int;
    logic [63:0] rsp_rdata, mtime;

    logic        r4_ready, r4_valid, r4_err, int4;
    logic [63:0] r4_rdata, mtime4;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mtimer #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timer_int_o(timer_int), .mtime_o(mtime)
    );

    mtimer #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(1'b0), .req_ready(r4_ready), .req_we(1'b0),
        .req_addr(64'd0), .req_wdata(64'd0), .req_wstrb(8'd0),
        .rsp_valid(r4_valid), .rsp_ready(1'b1), .rsp_rdata(r4_rdata),
        .rsp_err(r4_err), .timer_int_o(int4), .mtime_o(mtime4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a response and compares it with the oldest expectation.
    task automatic check_rsp(input string tag);
        exp_t e;
        int   n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".rdata"}, rsp_rdata, e.rdata);
            chk({tag, ".err"}, 64'(rsp_err), 64'(e.err));
        end
    endtask

    // Called at a negedge: issue, accept on the next posedge, check at the following negedge.
    task automatic xact_start(input string tag, input logic we, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] strb,
                              input logic [63:0] exp_rdata, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(negedge clk);
        check_rsp(tag);
    endtask

    task automatic xact_end();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int found;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.mtime", mtime, 64'd0);
        chk("rst.int", 64'(timer_int), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.rdata", rsp_rdata, 64'd0);
        rst_n = 1'b1;

        // Prescaler by 4: first increment on the 4th edge after release.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("div4.mtime4", mtime4, 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("div4.mtime8", mtime4, 64'd2);
        chk("div4.int", 64'(int4), 64'd0);

        // Compare threshold: interrupt one cycle after mtime reaches 10.
        xact_start("wr_mtime0", 1'b1, A_TIME, 64'd0, 8'hFF, 64'd0, 1'b0);
        xact_end();
        xact_start("wr_cmp10", 1'b1, A_CMP, 64'd10, 8'hFF, 64'd0, 1'b0);
        xact_end();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (mtime == 64'd10) begin
                chk("cmp10.int_at10", 64'(timer_int), 64'd0);
                @(negedge clk);
                chk("cmp10.int_after", 64'(timer_int), 64'd1);
                found = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk("cmp10.reached", 64'(found), 64'd1);
        xact_start("wr_cmp_ones", 1'b1, A_CMP, ONES, 8'hFF, 64'd0, 1'b0);
        chk("cmp_ones.int_hold", 64'(timer_int), 64'd1);
        xact_end();
        chk("cmp_ones.int_fall", 64'(timer_int), 64'd0);

        // 64-bit wrap.
        xact_start("wr_wrap", 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 1'b0);
        chk("wrap.fe", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        chk("wrap.ff", mtime, ONES);
        @(negedge clk);
        chk("wrap.0", mtime, 64'd0);
        @(negedge clk);
        chk("wrap.1", mtime, 64'd1);

        // Partial write on a tick edge suppresses the increment.
        xact_start("wr_pre", 1'b1, A_TIME, 64'h4_FFFF_FFFF, 8'hFF, 64'd0, 1'b0);
        chk("strb.pre", mtime, 64'h4_FFFF_FFFF);
        xact_end();
        chk("strb.tick", mtime, 64'h5_0000_0000);
        xact_start("wr_strb", 1'b1, A_TIME, 64'h1234_5678, 8'h0F, 64'd0, 1'b0);
        chk("strb.merge", mtime, 64'h5_1234_5678);
        xact_end();

        // Reads capture pre-edge values.
        xact_start("wr_m100", 1'b1, A_TIME, 64'd100, 8'hFF, 64'd0, 1'b0);
        xact_end();
        xact_start("rd_mtime", 1'b0, A_TIME, 64'd0, 8'h00, 64'd101, 1'b0);
        xact_end();
        xact_start("wr_cmp_hi", 1'b1, A_CMP, 64'h0123_4567_89AB_CDEF, 8'hF0, 64'd0, 1'b0);
        xact_end();
        xact_start("rd_cmp", 1'b0, A_CMP, 64'd0, 8'h00, 64'h0123_4567_FFFF_FFFF, 1'b0);
        xact_end();
        xact_start("wr_unmapped", 1'b1, A_CMP + 64'd4, 64'd0, 8'hFF, 64'd0, 1'b1);
        xact_end();
        xact_start("wr_nostrb", 1'b1, A_CMP, 64'd0, 8'h00, 64'd0, 1'b0);
        xact_end();
        xact_start("rd_cmp2", 1'b0, A_CMP, 64'd0, 8'h00, 64'h0123_4567_FFFF_FFFF, 1'b0);
        xact_end();
        xact_start("rd_misal", 1'b0, A_TIME + 64'd1, 64'd0, 8'h00, 64'd0, 1'b1);
        xact_end();

        // Error response held under backpressure.
        rsp_ready = 1'b0;
        xact_start("rd_base0", 1'b0, BASE, 64'd0, 8'h00, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp.valid", 64'(rsp_valid), 64'd1);
            chk("bp.err", 64'(rsp_err), 64'd1);
            chk("bp.rdata", rsp_rdata, 64'd0);
            chk("bp.req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        xact_end();
        chk("bp.released", 64'(rsp_valid), 64'd0);
        chk("bp.req_ready1", 64'(req_ready), 64'd1);

        // Reset mid-transaction drops the response asynchronously.
        rsp_ready = 1'b0;
        xact_start("rd_pre_rst", 1'b0, A_CMP, 64'd0, 8'h00, 64'h0123_4567_FFFF_FFFF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(rsp_valid), 64'd0);
        chk("arst.req_ready", 64'(req_ready), 64'd1);
        chk("arst.rdata", rsp_rdata, 64'd0);
        chk("arst.mtime", mtime, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("arst.no_stale", 64'(rsp_valid), 64'd0);
        xact_start("rd_cmp_rst", 1'b0, A_CMP, 64'd0, 8'h00, ONES, 1'b0);
        xact_end();
        chk("sb.empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
